// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and baud divisor helper.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } tx_state_t;

   // Clock cycles per bit; integer division truncates toward zero.
   function automatic int calc_baud_div(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count and a combinational read of the head entry.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serialiser producing 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    data_in,
   input  logic                          data_valid,
   output logic                          data_ready,
   output logic                          RsTx,
   output logic                          sending,
   output logic                          sent,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   import uart_pkg::*;

   localparam int BAUD_DIV = calc_baud_div(CLOCK_FREQ, BAUD_RATE);
   localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BIT_W    = $clog2(DATA_BITS);
   localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

   tx_state_t            state, state_next;
   logic [BW-1:0]        baud_cnt, baud_next;
   logic [BIT_W-1:0]     bit_cnt, bit_next;
   logic [DATA_BITS-1:0] shift_q, shift_next;
   logic [DATA_BITS-1:0] fifo_head;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 baud_done;
   logic                 tx_next;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_next;
`endif

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (data_valid),
      .pop     (fifo_pop),
      .wr_data (data_in),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign data_ready = !fifo_full;
   assign sending    = (state != IDLE);
   assign baud_done  = (baud_cnt == BAUD_LAST);

   // Every state change except leaving IDLE happens on baud_done, so the counter
   // restarts on each state entry as well as between data bits.
   always_comb begin
      state_next = state;
      shift_next = shift_q;
      bit_next   = bit_cnt;
      fifo_pop   = 1'b0;
      sent       = 1'b0;
      tx_next    = 1'b1;
      baud_next  = (state == IDLE || baud_done) ? '0 : baud_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_q;
`endif
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (baud_done) state_next = DATA;
         end
         DATA: begin
            if (baud_done) begin
               shift_next = shift_q >> 1;
               bit_next   = bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
               if (bit_cnt == BIT_LAST) state_next = PARITY;
`else
               if (bit_cnt == BIT_LAST) state_next = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_done) state_next = STOP;
         end
`endif
         STOP: begin
            if (baud_done) begin
               sent = 1'b1;
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (fifo_pop) begin
         shift_next = fifo_head;
         bit_next   = '0;
`ifdef UART_TX_PARITY_EN
         parity_next = ^fifo_head;
`endif
      end

      // The line level is registered from the next state to keep RsTx glitch-free.
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift_q  <= '0;
         RsTx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shift_q  <= shift_next;
         RsTx     <= tx_next;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_next;
`endif
      end
   end

endmodule
